uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx and uart_rx.
// Contents: receiver state encoding and frame constants
// (8 data bits, even parity).
package uart_pkg;

   localparam int DATA_BITS   = 8;
   localparam bit PARITY_EVEN = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output, two clk of latency
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sync1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= RESET_VAL;
         q     <= RESET_VAL;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB-first, even parity bit, stop bit.
// Produces one byte per frame, together with a one-cycle valid pulse.
// Ports:
//   clk, reset    - system clock; asynchronous, active-high reset
//   rx_serial_in  - serial line (idle high, asynchronous to clk)
//   rx_data       - last received byte; held until the next frame completes
//   rx_valid      - one-cycle pulse when rx_data and the error flags update
//   rx_parity_err - received parity bit disagrees with the data
//   rx_frame_err  - stop bit sampled low
//   rx_busy       - high while the FSM is away from IDLE
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | checking the start bit at mid-bit (glitch filter)
// DATA      | sampling the 8 data bits
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, publishing the result
// WAIT_HIGH | line still low after a bad stop; wait for idle
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   import uart_pkg::*;

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic ODD_ADJ = ~PARITY_EVEN;

   logic                 sync2;
   rx_state_t            state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next, cnt_wrap;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_bit;
   logic                 bit_sample;
   logic                 shift_en, par_en, stop_en;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_serial_in),
      .q     (sync2)
   );

   assign bit_sample = (cnt == LAST);
   assign cnt_wrap   = bit_sample ? '0 : cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_cnt_next = bit_cnt;
      shift_en     = 1'b0;
      par_en       = 1'b0;
      stop_en      = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!sync2) begin
               bit_cnt_next = '0;
               // With one or two clocks per bit there is no mid-start point
               // to re-check, so the start is accepted on detection.
               if (HALF == '0) begin
                  state_next = DATA;
               end else begin
                  state_next = START;
                  cnt_next   = CNT_W'(1);
               end
            end
         end
         START: begin
            if (cnt == HALF) begin
               cnt_next     = '0;
               bit_cnt_next = '0;
               state_next   = sync2 ? IDLE : DATA;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            cnt_next = cnt_wrap;
            if (bit_sample) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_next = '0;
                  state_next   = PARITY;
               end else begin
                  bit_cnt_next = bit_cnt + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            cnt_next = cnt_wrap;
            if (bit_sample) begin
               par_en     = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            cnt_next = cnt_wrap;
            if (bit_sample) begin
               stop_en    = 1'b1;
               state_next = sync2 ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (sync2) state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         par_bit       <= 1'b0;
         rx_data       <= 8'h00;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         bit_cnt  <= bit_cnt_next;
         rx_valid <= stop_en;
         rx_busy  <= (state_next != IDLE);
         if (shift_en) shift_reg[bit_cnt] <= sync2;
         if (par_en)   par_bit <= sync2;
         if (stop_en) begin
            rx_data       <= shift_reg;
            rx_parity_err <= par_bit ^ (^shift_reg) ^ ODD_ADJ;
            rx_frame_err  <= ~sync2;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       line1, line16;
   logic [7:0] data1, data16;
   logic       v1, pe1, fe1, busy1;
   logic       v16, pe16, fe16, busy16;

   int n_checks = 0;
   int n_fail   = 0;

   logic [9:0] q1[$];
   logic [9:0] q16[$];

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(1)) dut1 (
      .clk           (clk),
      .reset         (reset),
      .rx_serial_in  (line1),
      .rx_data       (data1),
      .rx_valid      (v1),
      .rx_parity_err (pe1),
      .rx_frame_err  (fe1),
      .rx_busy       (busy1)
   );

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk           (clk),
      .reset         (reset),
      .rx_serial_in  (line16),
      .rx_data       (data16),
      .rx_valid      (v16),
      .rx_parity_err (pe16),
      .rx_frame_err  (fe16),
      .rx_busy       (busy16)
   );

   // capture every valid pulse as {parity_err, frame_err, data}
   always @(negedge clk) begin
      if (v1)  q1.push_back({pe1, fe1, data1});
      if (v16) q16.push_back({pe16, fe16, data16});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] item1(input int i);
      return (q1.size() > i) ? q1[i] : 10'h3FF;
   endfunction

   task automatic drive_bit(input int which, input logic val, input int cycles);
      if (which == 1) line1 = val;
      else            line16 = val;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                             input logic stop, input int cpb, input int idle);
      drive_bit(which, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i], cpb);
      drive_bit(which, par, cpb);
      drive_bit(which, stop, cpb);
      if (idle > 0) drive_bit(which, 1'b1, idle);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b1;
      line1  = 1'b1;
      line16 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(data1), 32'h00);
      chk("rst_flags", 32'({v1, pe1, fe1, busy1}), 32'h0);
      chk("rst_busy16", 32'({v16, busy16}), 32'h0);
      reset = 1'b0;
      drive_bit(1, 1'b1, 4);

      // single frame A5, correct parity
      send_frame(1, 8'hA5, 1'b0, 1'b1, 1, 8);
      chk("a5_count", 32'(q1.size()), 1);
      chk("a5_item", 32'(item1(0)), 32'h0A5);
      chk("a5_busy", 32'(busy1), 0);
      q1.delete();

      // back-to-back frames with one idle cycle
      send_frame(1, 8'h00, 1'b0, 1'b1, 1, 1);
      send_frame(1, 8'hFF, 1'b0, 1'b1, 1, 1);
      send_frame(1, 8'h3C, 1'b0, 1'b1, 1, 8);
      chk("b2b_count", 32'(q1.size()), 3);
      chk("b2b_0", 32'(item1(0)), 32'h000);
      chk("b2b_1", 32'(item1(1)), 32'h0FF);
      chk("b2b_2", 32'(item1(2)), 32'h03C);
      q1.delete();

      // wrong parity on 01
      send_frame(1, 8'h01, 1'b0, 1'b1, 1, 8);
      chk("par_count", 32'(q1.size()), 1);
      chk("par_item", 32'(item1(0)), 32'h201);
      q1.delete();

      // bad stop, line held low
      send_frame(1, 8'h55, 1'b0, 1'b0, 1, 0);
      drive_bit(1, 1'b0, 5);
      chk("brk_count", 32'(q1.size()), 1);
      chk("brk_item", 32'(item1(0)), 32'h155);
      chk("brk_state", 32'(dut1.state), 32'(WAIT_HIGH));
      chk("brk_busy", 32'(busy1), 1);
      drive_bit(1, 1'b1, 10);
      chk("brk_idle_count", 32'(q1.size()), 1);
      chk("brk_idle_busy", 32'(busy1), 0);
      send_frame(1, 8'h12, 1'b0, 1'b1, 1, 8);
      chk("brk_next_count", 32'(q1.size()), 2);
      chk("brk_next_item", 32'(item1(1)), 32'h012);
      q1.delete();

      // 16 clk/bit: glitch then a real frame
      drive_bit(16, 1'b0, 3);
      drive_bit(16, 1'b1, 2);
      chk("glitch_busy_hi", 32'(busy16), 1);
      drive_bit(16, 1'b1, 40);
      chk("glitch_busy_lo", 32'(busy16), 0);
      chk("glitch_count", 32'(q16.size()), 0);
      send_frame(16, 8'hC3, 1'b0, 1'b1, 16, 40);
      chk("c3_count", 32'(q16.size()), 1);
      chk("c3_item", 32'((q16.size() > 0) ? q16[0] : 10'h3FF), 32'h0C3);

      // reset during data bit 4
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b1, 1);
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b1, 1);
      drive_bit(1, 1'b1, 1);
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b1, 1);
      chk("mid_busy", 32'(dut1.bit_cnt), 4);
      reset = 1'b1;
      line1 = 1'b1;
      #1;
      chk("mid_rst_data", 32'(data1), 32'h00);
      chk("mid_rst_flags", 32'({v1, pe1, fe1, busy1}), 32'h0);
      drive_bit(1, 1'b1, 2);
      reset = 1'b0;
      drive_bit(1, 1'b1, 15);
      chk("mid_no_valid", 32'(q1.size()), 0);
      send_frame(1, 8'h7E, 1'b0, 1'b1, 1, 8);
      chk("mid_next_count", 32'(q1.size()), 1);
      chk("mid_next_item", 32'(item1(0)), 32'h07E);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
